// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequencer between the execute stage and the shared multdiv unit
// Ports: clock/reset_n (async active-low); req_* request in with req_ready/stall;
// flush aborts; resp_* valid/ready response out; md_* drive/observe the multdiv unit.
// Optional: define MULTDIV_CTRL_TIMEOUT_EN to abort after TIMEOUT_CYCLES in ISSUE/WAIT.
module multdiv_ctrl #(
  parameter int TAG_W          = 5,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic             req_op,
  input  logic [31:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  input  logic             flush,
  output logic             stall,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic             resp_exception,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      md_operandA,
  output logic [15:0]      md_operandB,
  output logic             md_ctrl_MULT,
  output logic             md_ctrl_DIV,
  input  logic [31:0]      md_result,
  input  logic             md_exception,
  input  logic             md_inputRDY,
  input  logic             md_resultRDY
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, res_q, res_d;
  logic [15:0] b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic exc_q, exc_d, valid_q, valid_d, mult_q, mult_d, div_q, div_d;
  logic timeout;
`ifdef MULTDIV_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Counter sits at zero outside ISSUE/WAIT, so it is already clear on ISSUE entry.
  assign cnt_d   = (state_q == ISSUE || state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
  assign timeout = (state_q == ISSUE || state_q == WAIT) && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && !md_resultRDY;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = CNT_W'(TIMEOUT_CYCLES);
  assign timeout    = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    res_d   = res_q;
    exc_d   = exc_q;
    valid_d = valid_q;
    mult_d  = mult_q;
    div_d   = div_q;
    case (state_q)
      IDLE:
        if (req_valid && !flush) begin
          a_d     = req_a;
          b_d     = req_b;
          tag_d   = req_tag;
          mult_d  = !req_op;
          div_d   = req_op;
          state_d = ISSUE;
        end
      ISSUE, WAIT:
        if (flush) begin
          mult_d  = 1'b0;
          div_d   = 1'b0;
          state_d = IDLE;
        end else if (timeout) begin
          res_d   = '0;
          exc_d   = 1'b1;
          valid_d = 1'b1;
          mult_d  = 1'b0;
          div_d   = 1'b0;
          state_d = RESP;
        end else if (state_q == WAIT && md_resultRDY) begin
          res_d   = md_result;
          exc_d   = md_exception;
          valid_d = 1'b1;
          mult_d  = 1'b0;
          div_d   = 1'b0;
          state_d = RESP;
        end else if (state_q == ISSUE && md_inputRDY) begin
          state_d = WAIT;
        end
      RESP:
        if (flush || resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      valid_q <= 1'b0;
      mult_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      valid_q <= valid_d;
      mult_q  <= mult_d;
      div_q   <= div_d;
    end
  assign req_ready      = state_q == IDLE;
  assign stall          = req_valid & ~req_ready;
  assign resp_valid     = valid_q;
  assign resp_result    = res_q;
  assign resp_exception = exc_q;
  assign resp_tag       = tag_q;
  assign md_operandA    = a_q;
  assign md_operandB    = b_q;
  assign md_ctrl_MULT   = mult_q;
  assign md_ctrl_DIV    = div_q;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed bench for multdiv_ctrl with a multdiv model and a transaction scoreboard
module tb_multdiv_ctrl;
  localparam int TAG_W = 5;
  localparam int TO    = 8;
`ifdef MULTDIV_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_op = 1'b0, flush = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic req_ready, stall, resp_valid, resp_exception, md_ctrl_MULT, md_ctrl_DIV;
  logic [31:0] resp_result, md_operandA;
  logic [15:0] md_operandB;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0] md_result = '0;
  logic md_exception = 1'b0, md_inputRDY = 1'b0, md_resultRDY = 1'b0;
  int checks = 0, failures = 0;
  int mcnt = 0;
  bit md_hang = 1'b0;

  multdiv_ctrl #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .req_ready(req_ready),
    .flush(flush), .stall(stall), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_exception(resp_exception), .resp_tag(resp_tag),
    .md_operandA(md_operandA), .md_operandB(md_operandB), .md_ctrl_MULT(md_ctrl_MULT),
    .md_ctrl_DIV(md_ctrl_DIV), .md_result(md_result), .md_exception(md_exception),
    .md_inputRDY(md_inputRDY), .md_resultRDY(md_resultRDY));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic calc(input logic op, input logic [31:0] a, input logic [15:0] b,
                      output logic [31:0] r, output logic e);
    if (!op) begin r = 32'(a * {16'b0, b}); e = 1'b0; end
    else if (b == 16'd0) begin r = '0; e = 1'b1; end
    else begin r = a / {16'b0, b}; e = 1'b0; end
  endtask

  // Multdiv unit: takes the operands one cycle after a control line rises,
  // reports the result 16 cycles after it rose (never, when md_hang is set).
  always @(posedge clock) begin
    #1;
    if (!reset_n || !(md_ctrl_MULT || md_ctrl_DIV)) mcnt = 0;
    else mcnt++;
    md_inputRDY  = mcnt >= 1;
    md_resultRDY = mcnt == 16 && !md_hang;
    calc(md_ctrl_DIV, md_operandA, md_operandB, md_result, md_exception);
  end

  // Scoreboard: one transaction in flight or one response owed at a time.
  bit in_flight = 1'b0, pending = 1'b0;
  logic cur_op;
  logic [31:0] cur_a, exp_res;
  logic [15:0] cur_b;
  logic [TAG_W-1:0] cur_tag;
  logic exp_exc;
  int icnt;
  always @(negedge clock) begin
    #2;
    if (!reset_n) begin
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
      in_flight = 1'b0;
      pending   = 1'b0;
    end else begin
      chk("stall", stall, req_valid & ~req_ready);
      chk("ctrl_excl", md_ctrl_MULT & md_ctrl_DIV, 0);
      if (in_flight) begin
        chk("mult_line", md_ctrl_MULT, !cur_op);
        chk("div_line", md_ctrl_DIV, cur_op);
        chk("opA_held", md_operandA, cur_a);
        chk("opB_held", md_operandB, cur_b);
        chk("busy_ready", req_ready, 0);
        chk("busy_valid", resp_valid, 0);
        if (flush) in_flight = 1'b0;
        else if (TO_EN && icnt == TO - 1 && !md_resultRDY) begin
          in_flight = 1'b0; pending = 1'b1; exp_res = '0; exp_exc = 1'b1;
        end else if (md_resultRDY) begin
          in_flight = 1'b0; pending = 1'b1;
          calc(cur_op, cur_a, cur_b, exp_res, exp_exc);
        end
        icnt++;
      end else if (pending) begin
        chk("resp_valid", resp_valid, 1);
        chk("resp_result", resp_result, exp_res);
        chk("resp_exc", resp_exception, exp_exc);
        chk("resp_tag", resp_tag, cur_tag);
        chk("resp_ctrl_low", {md_ctrl_MULT, md_ctrl_DIV}, 0);
        chk("resp_ready_out", req_ready, 0);
        if (flush || resp_ready) pending = 1'b0;
      end else begin
        chk("idle_ready", req_ready, 1);
        chk("idle_valid", resp_valid, 0);
        chk("idle_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
        if (req_valid && !flush) begin
          in_flight = 1'b1; icnt = 0;
          cur_op = req_op; cur_a = req_a; cur_b = req_b; cur_tag = req_tag;
        end
      end
    end
  end

  task automatic wait_resp(input string name);
    int k = 0;
    do begin @(negedge clock); #3; k++; end while (!resp_valid && k < 100);
    if (!resp_valid) begin
      checks++; failures++;
      $display("FAIL %s: resp_valid never rose within 100 cycles", name);
    end
  endtask

  task automatic send(input logic op, input logic [31:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t);
    @(negedge clock);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = t;
  endtask

  task automatic chk_regs_zero(input string name);
    chk({name, "_valid"}, resp_valid, 0);
    chk({name, "_result"}, resp_result, 0);
    chk({name, "_exc"}, resp_exception, 0);
    chk({name, "_tag"}, resp_tag, 0);
    chk({name, "_opA"}, md_operandA, 0);
    chk({name, "_opB"}, md_operandB, 0);
    chk({name, "_ctrl"}, {md_ctrl_MULT, md_ctrl_DIV}, 0);
  endtask

  initial begin
    #1;
    chk_regs_zero("reset");
    chk("reset_req_ready", req_ready, 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    // 7 x 6
    send(1'b0, 32'd7, 16'd6, 5'd3);
    resp_ready = 1'b1;
    @(negedge clock);
    req_valid = 1'b0; req_a = 32'd999;
    #3;
    chk("mul_ctrl_rise", md_ctrl_MULT, 1);
    chk("mul_opA", md_operandA, 7);
    wait_resp("mul");
    chk("mul_result", resp_result, 42);
    chk("mul_exc", resp_exception, 0);
    chk("mul_tag", resp_tag, 3);
    @(negedge clock); #3;
    chk("mul_one_cycle", resp_valid, 0);
    // 100 / 7 with back-pressure and a second request queued behind it
    send(1'b1, 32'd100, 16'd7, 5'd9);
    resp_ready = 1'b0;
    @(negedge clock);
    req_op = 1'b0; req_a = 32'd3; req_b = 16'd5; req_tag = 5'd1;
    #3;
    chk("div_stall", stall, 1);
    chk("div_req_ready", req_ready, 0);
    chk("div_ctrl", md_ctrl_DIV, 1);
    chk("div_opA", md_operandA, 100);
    wait_resp("div");
    for (int i = 0; i < 5; i++) begin
      chk("div_hold_valid", resp_valid, 1);
      chk("div_hold_result", resp_result, 14);
      chk("div_hold_tag", resp_tag, 9);
      chk("div_hold_stall", stall, 1);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    #3;
    chk("div_still_valid", resp_valid, 1);
    @(negedge clock); #3;
    chk("accept_after_hs", req_ready, 1);
    chk("hs_valid_low", resp_valid, 0);
    @(negedge clock);
    req_valid = 1'b0;
    #3;
    chk("second_ctrl", md_ctrl_MULT, 1);
    chk("second_opA", md_operandA, 3);
    wait_resp("second");
    chk("second_result", resp_result, 15);
    chk("second_tag", resp_tag, 1);
    // 5 / 0
    send(1'b1, 32'd5, 16'd0, 5'd2);
    @(negedge clock);
    req_valid = 1'b0;
    wait_resp("div0");
    chk("div0_exc", resp_exception, 1);
    chk("div0_tag", resp_tag, 2);
    @(negedge clock); #3;
    chk("div0_idle", req_ready, 1);
    // flush coinciding with resultRDY
    send(1'b0, 32'd4, 16'd4, 5'd4);
    @(negedge clock);
    req_valid = 1'b0;
    begin
      int k = 0;
      do begin @(negedge clock); k++; end while (!md_resultRDY && k < 100);
      if (!md_resultRDY) begin
        checks++; failures++;
        $display("FAIL flush_wait: md_resultRDY never rose");
      end
    end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    #3;
    chk("flush_no_valid", resp_valid, 0);
    chk("flush_ctrl", {md_ctrl_MULT, md_ctrl_DIV}, 0);
    chk("flush_ready", req_ready, 1);
    @(negedge clock); #3;
    chk("flush_no_valid2", resp_valid, 0);
    // reset pulse mid-WAIT
    send(1'b0, 32'd8, 16'd8, 5'd5);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_regs_zero("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    send(1'b0, 32'd3, 16'd3, 5'd6);
    @(negedge clock);
    req_valid = 1'b0;
    wait_resp("post_rst");
    chk("post_rst_result", resp_result, 9);
    chk("post_rst_tag", resp_tag, 6);
`ifdef MULTDIV_CTRL_TIMEOUT_EN
    md_hang = 1'b1;
    send(1'b0, 32'd2, 16'd2, 5'd7);
    @(negedge clock);
    req_valid = 1'b0;
    #3;
    chk("to_issue", md_ctrl_MULT, 1);
    begin
      int n = 0;
      do begin @(negedge clock); #3; n++; end while (!resp_valid && n < 50);
      chk("to_latency", n, TO);
    end
    chk("to_exc", resp_exception, 1);
    chk("to_result", resp_result, 0);
    chk("to_tag", resp_tag, 7);
    md_hang = 1'b0;
`endif
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
